// File: rtl/cdb_arbiter_if.sv
// Common Data Bus bundle: per-unit request lanes in, registered broadcast out.
// Handshake: unit i transfers a result on a rising edge when req_valid[i] and req_ready[i] are both 1.
interface cdb_arbiter_if #(
  parameter int N  = 4,
  parameter int TW = 5,
  parameter int DW = 32,
  parameter int SW = 2
);
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_branch;
  logic [N-1:0]    req_taken;
  logic [N-1:0]    req_ready;

  logic [TW-1:0]   Cdb_rd_tag;
  logic            Cdb_valid;
  logic [DW-1:0]   Cdb_data;
  logic            Cdb_branch;
  logic            Cdb_branch_taken;
  logic [SW-1:0]   Cdb_src;

  modport master (
    output req_valid, req_tag, req_data, req_branch, req_taken,
    input  req_ready,
    input  Cdb_rd_tag, Cdb_valid, Cdb_data, Cdb_branch, Cdb_branch_taken, Cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data, req_branch, req_taken,
    output req_ready,
    output Cdb_rd_tag, Cdb_valid, Cdb_data, Cdb_branch, Cdb_branch_taken, Cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one holding buffer per execution unit, one registered
// broadcast per cycle, flush on mispredict. Pointer and held bits exported for debug.
module cdb_arbiter #(
  parameter int N  = 4,
  parameter int TW = 5,
  parameter int DW = 32,
  parameter int SW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus,
  output logic [SW-1:0] dbg_rr_ptr,
  output logic [N-1:0]  dbg_held
);

  logic [N-1:0]  held;
  logic [TW-1:0] hb_tag  [N];
  logic [DW-1:0] hb_data [N];
  logic [N-1:0]  hb_branch;
  logic [N-1:0]  hb_taken;
  logic [SW-1:0] rr_ptr;

  logic [N-1:0]  gnt;
  logic [SW-1:0] win;
  logic          found;
  logic [N-1:0]  accept;

  logic [TW-1:0] cdb_tag_q;
  logic [DW-1:0] cdb_data_q;
  logic          cdb_valid_q;
  logic          cdb_branch_q;
  logic          cdb_taken_q;
  logic [SW-1:0] cdb_src_q;

  // Scan from rr_ptr upward; SW-bit addition wraps modulo N since N is a power of 2.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && held[rr_ptr + SW'(j)]) begin
        found = 1'b1;
        win   = rr_ptr + SW'(j);
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  // A unit being granted this cycle may refill its buffer on the same edge.
  assign bus.req_ready = (reset || flush) ? '0 : (~held | gnt);
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held      <= '0;
      hb_branch <= '0;
      hb_taken  <= '0;
      for (int i = 0; i < N; i++) begin
        hb_tag[i]  <= '0;
        hb_data[i] <= '0;
      end
    end else if (flush) begin
      held <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (accept[i]) begin
          held[i]      <= 1'b1;
          hb_tag[i]    <= bus.req_tag[i*TW +: TW];
          hb_data[i]   <= bus.req_data[i*DW +: DW];
          hb_branch[i] <= bus.req_branch[i];
          hb_taken[i]  <= bus.req_taken[i];
        end else if (gnt[i]) begin
          held[i] <= 1'b0;
        end
      end
    end
  end

  // Payload registers keep their last value when no broadcast happens.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_branch_q <= 1'b0;
      cdb_taken_q  <= 1'b0;
      cdb_src_q    <= '0;
    end else if (found && !flush) begin
      rr_ptr       <= win + SW'(1);
      cdb_valid_q  <= 1'b1;
      cdb_tag_q    <= hb_tag[win];
      cdb_data_q   <= hb_data[win];
      cdb_branch_q <= hb_branch[win];
      cdb_taken_q  <= hb_taken[win];
      cdb_src_q    <= win;
    end else begin
      cdb_valid_q  <= 1'b0;
    end
  end

  assign bus.Cdb_valid        = cdb_valid_q;
  assign bus.Cdb_rd_tag       = cdb_tag_q;
  assign bus.Cdb_data         = cdb_data_q;
  assign bus.Cdb_branch       = cdb_branch_q;
  assign bus.Cdb_branch_taken = cdb_taken_q;
  assign bus.Cdb_src          = cdb_src_q;

  assign dbg_rr_ptr = rr_ptr;
  assign dbg_held   = held;

endmodule
